key_debounce: RTL and testbench

- Input-side counterpart to the board's LED output drivers. Reads one raw mechanical push-button on the 27 MHz sys_clk domain.
- Synchronizes and debounces the button, then reports:
  - a clean level;
  - single-cycle press and release pulses;
  - a single-cycle long-press pulse.
- Sits between a board key pin and the LED/mode control logic. Consumers act on pulses only and never see raw bounce.

---
 rtl/key_debounce.sv | 181 ++++++++++++++++++
 tb/tb_key_debounce.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchronizer, debounce FSM, and long-press timer for
// one mechanical push-button on the sys_clk domain.
// Outputs:
//   key_level   - clean pressed level
//   key_press   - one-cycle pulse on an accepted press
//   key_release - one-cycle pulse on an accepted release
//   key_long    - one-cycle pulse, at most once per press, after a long hold
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 540000,   // stable cycles to accept a change
  parameter int LONG_CYCLES     = 27000000, // debounced hold cycles before key_long
  parameter int KEY_ACTIVE_LOW  = 1         // 1: pin reads 0 while pressed
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  // Pin level while the button is untouched; the synchronizer resets to it
  // so that leaving reset never looks like an edge on an idle key.
  localparam logic IDLE_LVL = (KEY_ACTIVE_LOW != 0);

  // Counter compare points, cast once to the counter widths.
  localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [24:0] HOLD_LAST = 25'(LONG_CYCLES - 1);
  localparam logic [24:0] HOLD_SAT  = 25'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_e;

  state_e      state_q;
  state_e      state_d;

  logic        sync1_q;
  logic        sync2_q;
  logic        p;           // synchronized key, 1 = pressed

  logic [23:0] db_cnt_q;
  logic [23:0] db_cnt_d;
  logic [24:0] hold_cnt_q;
  logic [24:0] hold_cnt_d;

  logic        level_d;
  logic        press_d;
  logic        release_d;
  logic        long_d;

  // Two-flop synchronizer: the only place key_in is sampled.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // Normalize polarity so the rest of the block only thinks in "pressed".
  assign p = sync2_q ^ IDLE_LVL;

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a level change is accepted only after the synchronized
  // key has held the new value long enough; any opposite sample aborts.
  // NOTE: the default assignment at the top of every always_comb keeps each
  // path fully specified, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (p) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!p) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (!p) state_d = DB_RELEASE;
      end
      DB_RELEASE: begin
        if (p) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: next values of the counters, the clean level and
  // the single-cycle pulses. Pulses default low so each lasts one cycle.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = key_level;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (p) db_cnt_d = '0;
      end
      DB_PRESS: begin
        if (p) begin
          if (db_cnt_q == DB_LAST) begin
            level_d    = 1'b1;
            press_d    = 1'b1;
            hold_cnt_d = '0;
          end else begin
            db_cnt_d = db_cnt_q + 24'd1;
          end
        end
      end
      PRESSED: begin
        if (!p) begin
          // hold_cnt stays frozen while a possible release is qualified.
          db_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          // Park one past the fire point so key_long cannot repeat.
          long_d     = 1'b1;
          hold_cnt_d = HOLD_SAT;
        end else if (hold_cnt_q < HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 25'd1;
        end
      end
      DB_RELEASE: begin
        if (!p) begin
          if (db_cnt_q == DB_LAST) begin
            level_d    = 1'b0;
            release_d  = 1'b1;
            hold_cnt_d = '0;
          end else begin
            db_cnt_d = db_cnt_q + 24'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
      key_long    <= long_d;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scenarios plus randomized key traffic for
// key_debounce, compared against a run-length model of the debounce rules.
module tb_key_debounce;

  localparam int D = 8;
  localparam int L = 40;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_in = 1'b1;
  logic key_level, key_press, key_release, key_long;

  int n_checks = 0;
  int n_fail   = 0;
  int mism     = 0;   // cycles where the DUT diverged from the model

  key_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .KEY_ACTIVE_LOW (1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: the pin reaches the decision logic two edges late.
  // A level flips once D+1 consecutive samples disagree with it. While
  // pressed, every sample that agrees with a settled press adds one hold
  // cycle; key_long fires when the hold count reaches L, once per press.
  logic m_s1, m_s2, m_p;
  logic m_level, m_press, m_release, m_long;
  int   m_run, m_hold;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
      m_run = 0; m_hold = 0;
    end else begin
      m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
      m_p  = ~m_s2;
      m_s2 = m_s1;
      m_s1 = key_in;
      if (m_p != m_level) begin
        m_run = m_run + 1;
        if (m_run == D + 1) begin
          m_level   = m_p;
          m_press   = m_p;
          m_release = ~m_p;
          m_run  = 0;
          m_hold = 0;
        end
      end else begin
        if (m_level && m_run == 0 && m_hold < L) begin
          m_hold = m_hold + 1;
          if (m_hold == L) m_long = 1'b1;
        end
        m_run = 0;
      end
    end
  end

  // Cycle-by-cycle divergence tracker, sampled on the falling edge.
  always @(negedge sys_clk) begin
    if ({key_level, key_press, key_release, key_long} !==
        {m_level, m_press, m_release, m_long}) begin
      mism = mism + 1;
      $display("divergence at %0t: dut l/p/r/g=%b%b%b%b model=%b%b%b%b", $time,
               key_level, key_press, key_release, key_long,
               m_level, m_press, m_release, m_long);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Hold reset with the key pressed, then release and time the press.
  task automatic test_reset();
    int m0 = mism;
    sys_rst_n = 1'b0;
    key_in    = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    n_checks++;
    if ({key_level, key_press, key_release, key_long} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b%b%b%b, required 0000",
               key_level, key_press, key_release, key_long);
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge sys_clk); #1;
      n_checks++;
      if (key_press !== (i == 10) || key_level !== (i >= 10) || key_release !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_press edge %0d: got p=%b l=%b r=%b, required p=%b l=%b r=0",
                 i, key_press, key_level, key_release, i == 10, i >= 10);
      end
    end
    // Let go and settle back to idle.
    key_in = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1;
    n_checks++;
    if (key_level !== 1'b0 || mism !== m0) begin
      n_fail++;
      $display("FAIL reset_settle: got level=%b divergences=%0d, required 0 and 0",
               key_level, mism - m0);
    end
  endtask

  // Clean press held 60 cycles: press at edge 10, one long at edge 50.
  task automatic test_clean_press();
    int longs = 0;
    key_in = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge sys_clk); #1;
      if (key_long === 1'b1) longs++;
      n_checks++;
      if (key_press !== (i == 10) || key_long !== (i == 50)) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: got p=%b g=%b, required p=%b g=%b",
                 i, key_press, key_long, i == 10, i == 50);
      end
    end
    n_checks++;
    if (longs !== 1) begin
      n_fail++;
      $display("FAIL clean_press_long_count: got %0d, required 1", longs);
    end
    key_in = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1;
  endtask

  // Short low bursts must never be accepted.
  task automatic test_bounce();
    int pulses = 0;
    int lvl_hi = 0;
    for (int r = 0; r < 4; r++) begin
      key_in = 1'b0;
      repeat (5) begin
        @(posedge sys_clk); #1;
        pulses += int'(key_press) + int'(key_release) + int'(key_long);
        lvl_hi += int'(key_level);
      end
      key_in = 1'b1;
      repeat (3) begin
        @(posedge sys_clk); #1;
        pulses += int'(key_press) + int'(key_release) + int'(key_long);
        lvl_hi += int'(key_level);
      end
    end
    repeat (20) begin
      @(posedge sys_clk); #1;
      pulses += int'(key_press) + int'(key_release) + int'(key_long);
      lvl_hi += int'(key_level);
    end
    n_checks++;
    if (pulses !== 0 || lvl_hi !== 0) begin
      n_fail++;
      $display("FAIL bounce_reject: got %0d pulses, %0d level-high cycles, required 0 and 0",
               pulses, lvl_hi);
    end
  endtask

  // A 4-cycle release bounce while held: no release, long delayed by 5.
  task automatic test_release_bounce();
    key_in = 1'b0;
    for (int i = 0; i < 71; i++) begin
      @(posedge sys_clk); #1;
      n_checks++;
      if (key_press !== (i == 10) || key_long !== (i == 55) || key_release !== 1'b0 ||
          (i >= 10 && key_level !== 1'b1)) begin
        n_fail++;
        $display("FAIL release_bounce edge %0d: got p=%b g=%b r=%b l=%b, required p=%b g=%b r=0 l=%b",
                 i, key_press, key_long, key_release, key_level, i == 10, i == 55, i >= 10);
      end
      if (i == 30) key_in = 1'b1;
      if (i == 34) key_in = 1'b0;
    end
  endtask

  // Clean release after key_long, then a fresh press gets a fresh long.
  task automatic test_clean_release();
    key_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge sys_clk); #1;
      n_checks++;
      if (key_release !== (i == 10) || key_level !== (i < 10) || key_long !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_release edge %0d: got r=%b l=%b g=%b, required r=%b l=%b g=0",
                 i, key_release, key_level, key_long, i == 10, i < 10);
      end
    end
    key_in = 1'b0;
    for (int i = 0; i < 55; i++) begin
      @(posedge sys_clk); #1;
      n_checks++;
      if (key_press !== (i == 10) || key_long !== (i == 50)) begin
        n_fail++;
        $display("FAIL fresh_long edge %0d: got p=%b g=%b, required p=%b g=%b",
                 i, key_press, key_long, i == 10, i == 50);
      end
    end
    key_in = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1;
  endtask

  // Reset asserted mid release qualification: level drops at once, no release.
  task automatic test_async_reset();
    int bad = 0;
    key_in = 1'b0;
    repeat (12) @(posedge sys_clk);
    #1;
    n_checks++;
    if (key_level !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre_level: got %b, required 1", key_level);
    end
    key_in = 1'b1;
    repeat (6) @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (key_level !== 1'b0 || key_release !== 1'b0) begin
      n_fail++;
      $display("FAIL async_drop: got l=%b r=%b, required l=0 r=0", key_level, key_release);
    end
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (25) begin
      @(posedge sys_clk); #1;
      if ({key_level, key_press, key_release, key_long} !== 4'b0000) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL async_idle_after: got %0d non-idle cycles, required 0", bad);
    end
  endtask

  // Random burst lengths around and beyond the debounce threshold.
  task automatic test_random();
    int m0 = mism;
    int len;
    for (int n = 0; n < 150; n++) begin
      key_in = ~key_in;
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(9, 60));
      else                           len = int'($urandom_range(1, 11));
      repeat (len) @(posedge sys_clk);
      #1;
    end
    key_in = 1'b1;
    repeat (60) @(posedge sys_clk);
    #1;
    n_checks++;
    if (mism !== m0 || key_level !== 1'b0) begin
      n_fail++;
      $display("FAIL random_vs_model: got %0d divergent cycles level=%b, required 0 and 0",
               mism - m0, key_level);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_clean_release();
    test_async_reset();
    test_random();
    n_checks++;
    if (mism !== 0) begin
      n_fail++;
      $display("FAIL model_overall: got %0d divergent cycles, required 0", mism);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
